// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq - sequential signed divider (restoring, one quotient bit per cycle)
//
// Produces the quotient on lo_o and the remainder on hi_o. The quotient
// truncates toward zero, and the remainder takes the sign of the dividend.
//
// Ports
//   clk_i       system clock, rising edge
//   reset_i     asynchronous, active-high reset
//   start_i     one-cycle request, accepted only when idle and not busy
//   a_i         dividend, two's complement
//   b_i         divisor, two's complement
//   busy_o      operation in progress (from E0+1 through the done cycle)
//   done_o      one-cycle pulse; hi_o/lo_o hold the new result
//   div_zero_o  one-cycle pulse; divisor was zero, nothing was computed
//   hi_o        remainder (registered, held between operations)
//   lo_o        quotient  (registered, held between operations)
//
// State table
//   IDLE | waiting for start_i
//   RUN  | WIDTH restoring steps, one per cycle
//   FIN  | sign fix-up; hi/lo and done are registered on leaving FIN
// ---------------------------------------------------------------------------
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // Magnitudes are plain unsigned WIDTH-bit values; the most negative
  // number negates to itself, which is exactly its magnitude.
  assign a_mag = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  // Trial step: shift the next dividend bit into the remainder and compare
  // at WIDTH+1 bits so a carried-out remainder bit is not lost.
  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;
    // busy lags the state by one cycle, so it covers the done cycle too.
    busy_d    = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        // busy_q is still high in the done cycle; a start there is dropped.
        if (start_i && !busy_q) begin
          if (b_i == '0) begin
            dz_d = 1'b1;
          end else begin
            dvd_d     = a_mag;
            dvs_d     = b_mag;
            rem_d     = '0;
            neg_quo_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_rem_d = a_i[WIDTH-1];
            cnt_d     = CNT_W'(WIDTH);
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        // When ge is set the difference is below dvs_q, so WIDTH bits suffice.
        rem_d = ge ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        lo_d    = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        hi_d    = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign div_zero_o = dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (div_zero),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Reference: exact signed division in 64-bit arithmetic, truncated to 32 bits.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endtask

  task automatic pulse_start(input logic [31:0] sa, input logic [31:0] sb);
    @(negedge clk);
    a = sa;
    b = sb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 45) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
  endtask

  task automatic do_div(input string name, input logic [31:0] da, input logic [31:0] db,
                        input logic [31:0] elo, input logic [31:0] ehi);
    int n;
    pulse_start(da, db);
    wait_done(n);
    check({name, " latency"}, 32'(n), 32'd33);
    check({name, " lo"}, lo, elo);
    check({name, " hi"}, hi, ehi);
    check({name, " busy in done"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check({name, " done low after"}, {31'd0, done}, 32'd0);
    check({name, " busy low after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [31:0] ra, rb, eq, er;

    vecs[0] = '{32'd7,        32'd2,        32'd3,        32'd1};
    vecs[1] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF};
    vecs[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    vecs[5] = '{32'd3,        32'd10,       32'd0,        32'd3};
    vecs[6] = '{32'd0,        32'd5,        32'd0,        32'd0};
    vecs[7] = '{32'h80000000, 32'd1,        32'h80000000, 32'd0};
    vecs[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0};
    vecs[9] = '{32'd100,      32'd7,        32'd14,       32'd2};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset dz", {31'd0, div_zero}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);
    end

    // Divide by zero after the 100/7 preload: results retained, no done.
    pulse_start(32'd5, 32'd0);
    check("dz pulse", {31'd0, div_zero}, 32'd1);
    check("dz busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    check("dz one cycle", {31'd0, div_zero}, 32'd0);
    check("dz busy later", {31'd0, busy}, 32'd0);
    count_done(36, pulses);
    check("dz no done", 32'(pulses), 32'd0);
    check("dz lo kept", lo, 32'd14);
    check("dz hi kept", hi, 32'd2);

    // Start re-pulsed while busy must be ignored.
    pulse_start(32'd1000, 32'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    pulse_start(32'd9, 32'd3);
    n = 5;
    while (!done && n < 45) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ign latency", 32'(n), 32'd33);
    check("ign lo", lo, 32'd333);
    check("ign hi", hi, 32'd1);
    count_done(40, pulses);
    check("ign single done", 32'(pulses), 32'd0);

    // Start in the done cycle is ignored; accepted one cycle later.
    pulse_start(32'd50, 32'd7);
    wait_done(n);
    check("b2b latency", 32'(n), 32'd33);
    a = 32'd9;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("b2b busy after dropped start", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n);
    check("b2b second latency", 32'(n), 32'd33);
    check("b2b lo", lo, 32'd4);
    check("b2b hi", hi, 32'd1);

    // Asynchronous reset mid-operation.
    pulse_start(32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_done(40, pulses);
    check("rst no done", 32'(pulses), 32'd0);
    do_div("post-rst", 32'd1000, 32'd3, 32'd333, 32'd1);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 2) == 0) rb = $urandom;
      else rb = 32'($urandom_range(1, 300));
      if ($urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      model(ra, rb, eq, er);
      do_div($sformatf("rnd%0d", i), ra, rb, eq, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential signed divider for the multicycle CPU.
- Acts as the responder to the control unit's divide request: the control unit raises a one-cycle start, and this block answers with a done pulse or a div_zero pulse.
- Operands come from registers A and B. Results go to the HI/LO input muxes: quotient to LO, remainder to HI, with MIPS DIV semantics.
- Implementation is a one-bit-per-cycle restoring divider with an explicit FSM.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from the control unit; sampled only in IDLE.
- a  input  WIDTH  dividend (register A), two's complement.
- b  input  WIDTH  divisor (register B), two's complement.
- busy  output  1  high while in RUN or FIN.
- done  output  1  one-cycle pulse; hi/lo are valid and updated.
- div_zero  output  1  one-cycle pulse; divisor was zero and no operation was performed.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.

Behaviour:
- Reset (asynchronous, any state): state to IDLE; busy, done, div_zero, hi, lo, counter and internal registers all to 0.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 and b==0: stay in IDLE; div_zero=1 for exactly the next cycle; hi/lo unchanged; done stays 0.
  - start=1 and b!=0: latch |a| into the quotient/dividend shift register and |b| into the divisor register; clear the partial remainder; latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB]; counter=WIDTH; go to RUN.
  - Magnitudes are unsigned WIDTH bits, so |0x80000000| = 0x80000000.
- RUN, one restoring step per cycle:
  - Shift {rem, dvd} left by 1.
  - If the shifted rem >= divisor (unsigned, WIDTH+1-bit compare), subtract the divisor and set the quotient LSB to 1; otherwise set it to 0.
  - Decrement the counter; when the counter reaches 1 at the edge, go to FIN.
  - Exactly WIDTH cycles are spent in RUN.
- FIN:
  - lo <= sign_q ? -q : q; hi <= sign_r ? -rem : rem (truncation toward zero; the remainder takes the dividend's sign).
  - done=1 for this one cycle; next state IDLE.
- Latency: start sampled at edge E0 means done is high and hi/lo valid in the cycle after edge E0+WIDTH+1, i.e. 33 cycles for WIDTH=32. busy is high from E0+1 through the done cycle.
- start while busy is ignored; operand changes on a/b during RUN/FIN have no effect.
- start in the same cycle as done (FIN) is ignored; start is accepted from the first IDLE cycle after done.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, done pulses normally, no flag.
- Dividend 0 with nonzero divisor: lo=0, hi=0.
- |a| < |b|: lo=0, hi=a.
- hi/lo hold their value indefinitely between operations and after div_zero.
- Reset asserted mid-RUN: operation abandoned, outputs zeroed, no done pulse after reset release.
- Arithmetic width rule: all internal datapath is WIDTH bits except the WIDTH+1-bit trial subtraction. Negation is two's complement modulo 2^WIDTH.

Test Plan:
- a=7, b=2, one-cycle start -> 33 cycles later done=1 for one cycle; lo=0x00000003, hi=0x00000001; busy low the cycle after.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=0x00000001.
- Preload via a=100, b=7 (lo=14, hi=2); then a=5, b=0, start -> div_zero=1 for one cycle the next cycle; done never asserts; busy stays 0; lo=14 and hi=2 retained.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then a=3, b=10 -> lo=0, hi=3.
- a=1000, b=3 started; start re-pulsed at cycle 5 with a=9, b=3 -> ignored; single done at cycle 33 with lo=333, hi=1.
- a=1000, b=3 started; reset pulsed at cycle 10 -> hi=lo=0 and busy=0 immediately (asynchronous); no done within 40 cycles. A fresh start with a=1000, b=3 then completes normally.
